// File: rtl/fm_operator_nco.sv
// FM operator: phase accumulator plus quarter-wave sine lookup.
// Three-stage pipeline: address, ROM read, sign and output register.
module fm_operator_nco #(
  parameter int NUM_BITS = 32,
  parameter int WI       = 2,
  parameter int WF       = 16,
  parameter int LUT_BITS = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_en,
  input  logic                       phase_sync,
  input  logic [NUM_BITS-1:0]        tuning_word,
  output logic [NUM_BITS-1:0]        phase,
  output logic signed [WI+WF-1:0]    wave_out,
  output logic                       wave_valid
);

  localparam int W     = WI + WF;
  localparam int DEPTH = 1 << LUT_BITS;
  localparam int FX    = 60;
  localparam logic [127:0] ONE = 128'(1) << FX;

  // arctan(1/n) in Q.60, used to build pi via Machin's formula
  function automatic logic [127:0] atan_inv(input int n);
    logic [127:0] pw;
    logic [127:0] sum;
    pw  = ONE / 128'(n);
    sum = pw;
    for (int k = 1; k < 40; k++) begin
      pw = pw / 128'(n * n);
      if (k % 2 == 1)
        sum = sum - pw / 128'(2 * k + 1);
      else
        sum = sum + pw / 128'(2 * k + 1);
    end
    return sum;
  endfunction

  localparam logic [127:0] PI_S =
    128'(16) * atan_inv(5) - 128'(4) * atan_inv(239);

  // Rounded table entry, Taylor series in Q.60 at elaboration time
  function automatic logic [WF:0] sin_entry(
    input int           i,
    input logic [127:0] pi_s
  );
    logic [127:0] x;
    logic [127:0] x2;
    logic [127:0] term;
    logic [127:0] sum;
    logic [127:0] r;
    x    = (pi_s * 128'(2 * i + 1)) >> (LUT_BITS + 2);
    x2   = (x * x) >> FX;
    term = x;
    sum  = x;
    for (int k = 1; k < 20; k++) begin
      term = ((term * x2) >> FX) / 128'((2 * k) * (2 * k + 1));
      if (k % 2 == 1)
        sum = sum - term;
      else
        sum = sum + term;
    end
    r = (sum * (128'(1) << WF) + (128'(1) << (FX - 1))) >> FX;
    return r[WF:0];
  endfunction

  logic [WF:0] rom [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    localparam logic [WF:0] VAL = sin_entry(gi, PI_S);
    assign rom[gi] = VAL;
  end

  logic [1:0]          q_in;
  logic [LUT_BITS-1:0] a_raw;
  logic [LUT_BITS-1:0] a_in;

  always_comb begin
    q_in  = phase_sync ? 2'b00 : phase[NUM_BITS-1 -: 2];
    a_raw = phase_sync ? '0 : phase[NUM_BITS-3 -: LUT_BITS];
    a_in  = q_in[0] ? ~a_raw : a_raw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      phase <= '0;
    else if (phase_sync)
      phase <= sample_en ? tuning_word : '0;
    else if (sample_en)
      phase <= phase + tuning_word;
  end

  logic                s1_v;
  logic                s1_neg;
  logic [LUT_BITS-1:0] s1_addr;
  logic                s2_v;
  logic                s2_neg;
  logic [WF:0]         rom_q;
  logic signed [W-1:0] mag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_neg  <= 1'b0;
      s1_addr <= '0;
    end else begin
      s1_v    <= sample_en;
      s1_neg  <= q_in[1];
      s1_addr <= a_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v   <= 1'b0;
      s2_neg <= 1'b0;
      rom_q  <= '0;
    end else begin
      s2_v   <= s1_v;
      s2_neg <= s1_neg;
      rom_q  <= rom[s1_addr];
    end
  end

  assign mag = {{(WI-1){1'b0}}, rom_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wave_valid <= 1'b0;
      wave_out   <= '0;
    end else begin
      wave_valid <= s2_v;
      if (s2_v)
        wave_out <= s2_neg ? -mag : mag;
    end
  end

endmodule
